// File: rtl/addsub_serial_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master drives a request; the slave (the arithmetic unit) returns status and results.
interface addsub_serial_if #(
    parameter int BITS = 4
);
    logic            start;
    logic            mode;
    logic [BITS-1:0] num1;
    logic [BITS-1:0] num2;
    logic            busy;
    logic            done;
    logic [BITS-1:0] result;
    logic            carryout;
    logic            negative;
    logic            zero;

    modport master (
        output start, mode, num1, num2,
        input  busy, done, result, carryout, negative, zero
    );

    modport slave (
        input  start, mode, num1, num2,
        output busy, done, result, carryout, negative, zero
    );
endinterface

// File: rtl/addsub_serial.sv
// Bit-serial unsigned adder/subtractor, LSB first, one bit per clock.
// Subtraction yields sign+magnitude; results only change at the end of an operation.
module addsub_serial #(
    parameter int BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    addsub_serial_if.slave    bus
);
    localparam int CW = $clog2(BITS);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_reg;
    logic [BITS-1:0] a_reg;
    logic [BITS-1:0] b_reg;
    logic [BITS-1:0] raw_reg;
    logic            c_reg;
    logic            mode_reg;
    logic [CW-1:0]   cnt_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [BITS-1:0] result_reg;
    logic            carry_reg;
    logic            neg_reg;
    logic            zero_reg;

    logic            sum_bit;
    logic            c_next;
    logic            neg_next;
    logic [BITS-1:0] result_next;

    // Full adder on the current LSBs; subtraction already has ~num2 and carry-in 1.
    assign sum_bit = a_reg[0] ^ b_reg[0] ^ c_reg;
    assign c_next  = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);

    // No carry out of a subtraction means a borrow: negate the raw difference.
    assign neg_next    = mode_reg & ~c_reg;
    assign result_next = neg_next ? (~raw_reg + BITS'(1)) : raw_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            raw_reg    <= '0;
            c_reg      <= 1'b0;
            mode_reg   <= 1'b0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            neg_reg    <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_reg     <= bus.num1;
                        b_reg     <= bus.mode ? ~bus.num2 : bus.num2;
                        c_reg     <= bus.mode;
                        mode_reg  <= bus.mode;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= CALC;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    raw_reg <= {sum_bit, raw_reg[BITS-1:1]};
                    c_reg   <= c_next;
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(BITS - 1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    result_reg <= result_next;
                    carry_reg  <= c_reg;
                    neg_reg    <= neg_next;
                    zero_reg   <= (result_next == '0);
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b1;
                    state_reg  <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.result   = result_reg;
    assign bus.carryout = carry_reg;
    assign bus.negative = neg_reg;
    assign bus.zero     = zero_reg;
endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: a 4-bit and an 8-bit instance checked every cycle
// against an arithmetic model, plus directed vectors with literal expectations.
module tb_addsub_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    addsub_serial_if #(.BITS(4)) if4();
    addsub_serial_if #(.BITS(8)) if8();

    addsub_serial #(.BITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    addsub_serial #(.BITS(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {zero, negative, carryout, result[7:0]} straight from the arithmetic rules.
    function automatic logic [10:0] model(input int bits, input bit m, input int a, input int b);
        int r;
        bit c;
        bit n;
        if (!m) begin
            r = (a + b) & ((1 << bits) - 1);
            c = ((a + b) >> bits) != 0;
            n = 1'b0;
        end else if (a >= b) begin
            r = a - b;
            c = 1'b1;
            n = 1'b0;
        end else begin
            r = b - a;
            c = 1'b0;
            n = 1'b1;
        end
        return {(r == 0), n, c, r[7:0]};
    endfunction

    // Phase 0 idle, 1..BITS+1 busy, BITS+2 the done cycle.
    int ph4 = 0;
    int ph8 = 0;
    logic [10:0] exp4 = '0, pend4 = '0, exp8 = '0, pend8 = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph4 = 0;
            exp4 = '0;
        end else if (ph4 == 0 || ph4 == 6) begin
            if (if4.start) begin
                pend4 = model(4, if4.mode, int'(if4.num1), int'(if4.num2));
                ph4 = 1;
            end else begin
                ph4 = 0;
            end
        end else begin
            ph4++;
            if (ph4 == 6) exp4 = pend4;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph8 = 0;
            exp8 = '0;
        end else if (ph8 == 0 || ph8 == 10) begin
            if (if8.start) begin
                pend8 = model(8, if8.mode, int'(if8.num1), int'(if8.num2));
                ph8 = 1;
            end else begin
                ph8 = 0;
            end
        end else begin
            ph8++;
            if (ph8 == 10) exp8 = pend8;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                chk("busy4", int'(if4.busy), int'(ph4 >= 1 && ph4 <= 5));
                chk("done4", int'(if4.done), int'(ph4 == 6));
                chk("result4", int'(if4.result), int'(exp4[3:0]));
                chk("carry4", int'(if4.carryout), int'(exp4[8]));
                chk("neg4", int'(if4.negative), int'(exp4[9]));
                chk("zero4", int'(if4.zero), int'(exp4[10]));
                chk("busy8", int'(if8.busy), int'(ph8 >= 1 && ph8 <= 9));
                chk("done8", int'(if8.done), int'(ph8 == 10));
                chk("result8", int'(if8.result), int'(exp8[7:0]));
                chk("carry8", int'(if8.carryout), int'(exp8[8]));
                chk("neg8", int'(if8.negative), int'(exp8[9]));
                chk("zero8", int'(if8.zero), int'(exp8[10]));
            end
        end
    end

    task automatic start_op(input bit wide, input bit m, input int a, input int b);
        if (wide) begin
            if8.start = 1'b1; if8.mode = m; if8.num1 = 8'(a); if8.num2 = 8'(b);
        end else begin
            if4.start = 1'b1; if4.mode = m; if4.num1 = 4'(a); if4.num2 = 4'(b);
        end
    endtask

    // Counts cycles from the request to the done pulse; -1 if it never arrives.
    task automatic wait_done(input bit wide, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if4.start = 1'b0;
                if8.start = 1'b0;
            end
            if (wide ? if8.done : if4.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic outs(input bit wide, input string name, input int r, input int c, input int n, input int z);
        if (wide) begin
            chk({name, ".result"}, int'(if8.result), r);
            chk({name, ".carry"}, int'(if8.carryout), c);
            chk({name, ".neg"}, int'(if8.negative), n);
            chk({name, ".zero"}, int'(if8.zero), z);
        end else begin
            chk({name, ".result"}, int'(if4.result), r);
            chk({name, ".carry"}, int'(if4.carryout), c);
            chk({name, ".neg"}, int'(if4.negative), n);
            chk({name, ".zero"}, int'(if4.zero), z);
        end
        $display("[TB] %s: result=%0d carry=%0d neg=%0d zero=%0d", name,
                 wide ? int'(if8.result) : int'(if4.result),
                 wide ? int'(if8.carryout) : int'(if4.carryout),
                 wide ? int'(if8.negative) : int'(if4.negative),
                 wide ? int'(if8.zero) : int'(if4.zero));
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;
        if4.start = 1'b0; if4.mode = 1'b0; if4.num1 = '0; if4.num2 = '0;
        if8.start = 1'b0; if8.mode = 1'b0; if8.num1 = '0; if8.num2 = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy4", int'(if4.busy), 0);
        chk("reset.done4", int'(if4.done), 0);
        outs(1'b0, "reset4", 0, 0, 0, 0);
        outs(1'b1, "reset8", 0, 0, 0, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // sub 9-3 with latency and busy-length check
        @(negedge clk);
        start_op(1'b0, 1'b1, 9, 3);
        busy_cnt = 0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) if4.start = 1'b0;
            if (if4.busy) busy_cnt++;
            if (if4.done) begin
                lat = i;
                break;
            end
        end
        chk("sub9_3.latency", lat, 6);
        chk("sub9_3.busy_cycles", busy_cnt, 5);
        outs(1'b0, "sub9_3", 6, 1, 0, 0);

        @(negedge clk); start_op(1'b0, 1'b1, 3, 9); wait_done(1'b0, lat);
        chk("sub3_9.latency", lat, 6);
        outs(1'b0, "sub3_9", 6, 0, 1, 0);

        @(negedge clk); start_op(1'b0, 1'b0, 12, 7); wait_done(1'b0, lat);
        outs(1'b0, "add12_7", 3, 1, 0, 0);

        @(negedge clk); start_op(1'b0, 1'b0, 0, 0); wait_done(1'b0, lat);
        outs(1'b0, "add0_0", 0, 0, 0, 1);

        @(negedge clk); start_op(1'b0, 1'b1, 5, 5); wait_done(1'b0, lat);
        outs(1'b0, "sub5_5", 0, 1, 0, 1);

        @(negedge clk); start_op(1'b0, 1'b0, 15, 15); wait_done(1'b0, lat);
        outs(1'b0, "add15_15", 14, 1, 0, 0);

        @(negedge clk); start_op(1'b0, 1'b1, 0, 15); wait_done(1'b0, lat);
        outs(1'b0, "sub0_15", 15, 0, 1, 0);

        // Operand/mode changes and a start pulse while busy are ignored
        @(negedge clk);
        start_op(1'b0, 1'b1, 9, 3);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) if4.start = 1'b0;
            if (i == 2) start_op(1'b0, 1'b0, 0, 15);
            if (i == 3) if4.start = 1'b0;
            if (if4.done) begin
                lat = i;
                break;
            end
        end
        chk("ignore.latency", lat, 6);
        outs(1'b0, "ignore_busy", 6, 1, 0, 0);

        // Reset in the middle of an operation aborts it without a done pulse
        @(negedge clk);
        start_op(1'b0, 1'b0, 7, 8);
        @(negedge clk); if4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.busy", int'(if4.busy), 0);
        outs(1'b0, "abort", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if4.done) done_cnt++;
        end
        chk("abort.no_done", done_cnt, 0);

        // 8-bit: sub 0-255, then a new op requested in the done cycle
        @(negedge clk); start_op(1'b1, 1'b1, 0, 255); wait_done(1'b1, lat);
        chk("sub0_255.latency", lat, 10);
        outs(1'b1, "sub0_255", 255, 0, 1, 0);
        start_op(1'b1, 1'b0, 200, 100); wait_done(1'b1, lat);
        chk("b2b.latency", lat, 10);
        outs(1'b1, "add200_100", 44, 1, 0, 0);
        @(negedge clk); start_op(1'b1, 1'b1, 200, 55); wait_done(1'b1, lat);
        outs(1'b1, "sub200_55", 145, 1, 0, 0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
